// File: rtl/shift_reg_pkg.sv
// Shared definitions for the 4-bit universal shift register and its monitor:
// mode encodings, direction constants and the next-state helpers.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT     = 2'b00,
        MODE_ROTATE    = 2'b01,
        MODE_PARA_LOAD = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    localparam int unsigned REG_W = 4;

    // Next parallel value of the register for one enabled clock edge.
    function automatic logic [REG_W-1:0] next_q(
        input logic [1:0]       mode,
        input logic             dir,
        input logic             s_in,
        input logic [REG_W-1:0] q,
        input logic [REG_W-1:0] d
    );
        logic [REG_W-1:0] nq;
        nq = q;
        case (mode_e'(mode))
            MODE_PARA_LOAD: nq = d;
            MODE_SHIFT: begin
                if (dir == DIR_RIGHT) nq = {s_in, q[REG_W-1:1]};
                else                  nq = {q[REG_W-2:0], s_in};
            end
            MODE_ROTATE: begin
                if (dir == DIR_RIGHT) nq = {q[0], q[REG_W-1:1]};
                else                  nq = {q[REG_W-2:0], q[REG_W-1]};
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

    // Serial output only changes on a shift: it takes the bit pushed out.
    function automatic logic next_sout(
        input logic [1:0]       mode,
        input logic             dir,
        input logic [REG_W-1:0] q,
        input logic             sout
    );
        logic ns;
        ns = sout;
        if (mode_e'(mode) == MODE_SHIFT) begin
            ns = (dir == DIR_RIGHT) ? q[0] : q[REG_W-1];
        end
        return ns;
    endfunction

endpackage

// File: rtl/shift_reg_model.sv
// Cycle-accurate reference model of the universal shift register.
// With MONITOR_SOUT_CHECK_EN defined it also tracks the expected serial output.
module shift_reg_model
    import shift_reg_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enb,
    input  logic             i_dir,
    input  logic             i_s_in,
    input  logic [1:0]       i_modo,
    input  logic [REG_W-1:0] i_d,
    output logic [REG_W-1:0] o_exp_q,
`ifdef MONITOR_SOUT_CHECK_EN
    output logic             o_exp_sout,
`endif
    output logic             o_model_valid
);

    logic [REG_W-1:0] r_exp_q;
    logic             r_model_valid;
    logic [REG_W-1:0] w_next_q;
    logic             w_seed;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_q = r_exp_q;
        w_seed   = 1'b0;
        if (i_enb) begin
            w_next_q = next_q(i_modo, i_dir, i_s_in, r_exp_q, i_d);
            w_seed   = (mode_e'(i_modo) == MODE_PARA_LOAD);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, matching the register being checked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp_q       <= '0;
            r_model_valid <= 1'b0;
        end else begin
            r_exp_q <= w_next_q;
            if (w_seed) r_model_valid <= 1'b1;
        end
    end

`ifdef MONITOR_SOUT_CHECK_EN
    logic r_exp_sout;
    logic w_next_sout;

    always_comb begin
        w_next_sout = r_exp_sout;
        if (i_enb) w_next_sout = next_sout(i_modo, i_dir, r_exp_q, r_exp_sout);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_exp_sout <= 1'b0;
        else          r_exp_sout <= w_next_sout;
    end

    assign o_exp_sout = r_exp_sout;
`endif

    assign o_exp_q       = r_exp_q;
    assign o_model_valid = r_model_valid;

endmodule

// File: rtl/shift_reg_monitor.sv
// Output-side checker for the 4-bit universal shift register: reference model,
// per-edge compare, sticky flag and saturating counters. Macro: MONITOR_SOUT_CHECK_EN.
module shift_reg_monitor
    import shift_reg_pkg::*;
#(
    parameter int ERR_CNT_W = 8,
    parameter int CHK_CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ENB,
    input  logic                 DIR,
    input  logic                 S_IN,
    input  logic [1:0]           MODO,
    input  logic [3:0]           D,
    input  logic [3:0]           Q,
    input  logic                 S_OUT,
    output logic [3:0]           EXP_Q,
    output logic                 MODEL_VALID,
    output logic                 ERR,
    output logic                 ERR_STICKY,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic [CHK_CNT_W-1:0] CHK_CNT
);

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);
    localparam logic [CHK_CNT_W-1:0] CHK_ONE = CHK_CNT_W'(1);

    logic [3:0]           w_exp_q;
    logic                 w_model_valid;
    logic                 w_mismatch;
    logic                 r_err;
    logic                 r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [CHK_CNT_W-1:0] r_chk_cnt;

`ifdef MONITOR_SOUT_CHECK_EN
    logic w_exp_sout;
`else
    logic w_unused_sout;
    assign w_unused_sout = S_OUT;
`endif

    shift_reg_model u_model (
        .i_clk         (CLK),
        .i_rst_n       (RST_N),
        .i_enb         (ENB),
        .i_dir         (DIR),
        .i_s_in        (S_IN),
        .i_modo        (MODO),
        .i_d           (D),
        .o_exp_q       (w_exp_q),
`ifdef MONITOR_SOUT_CHECK_EN
        .o_exp_sout    (w_exp_sout),
`endif
        .o_model_valid (w_model_valid)
    );

    // Compare uses pre-edge values: the model's state for this cycle against
    // what the register is presenting now.
`ifdef MONITOR_SOUT_CHECK_EN
    assign w_mismatch = (Q != w_exp_q) || (S_OUT != w_exp_sout);
`else
    assign w_mismatch = (Q != w_exp_q);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
            r_chk_cnt    <= '0;
        end else if (w_model_valid) begin
            r_err <= w_mismatch;
            if (r_chk_cnt != '1) r_chk_cnt <= r_chk_cnt + CHK_ONE;
            if (w_mismatch) begin
                r_err_sticky <= 1'b1;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_ONE;
            end
        end else begin
            r_err <= 1'b0;
        end
    end

    assign EXP_Q       = w_exp_q;
    assign MODEL_VALID = w_model_valid;
    assign ERR         = r_err;
    assign ERR_STICKY  = r_err_sticky;
    assign ERR_CNT     = r_err_cnt;
    assign CHK_CNT     = r_chk_cnt;

endmodule

// File: tb/tb_shift_reg_monitor.sv
// Directed bench for shift_reg_monitor: hand-computed register traces are fed
// in as Q/S_OUT and the monitor's outputs are compared against fixed values.
module tb_shift_reg_monitor;
    import shift_reg_pkg::*;

`ifdef MONITOR_SOUT_CHECK_EN
    localparam int SOUT_EN = 1;
`else
    localparam int SOUT_EN = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        enb;
    logic        dir;
    logic        s_in;
    logic [1:0]  modo;
    logic [3:0]  d;
    logic [3:0]  q;
    logic        s_out;
    logic [3:0]  exp_q;
    logic        model_valid;
    logic        err;
    logic        err_sticky;
    logic [7:0]  err_cnt;
    logic [15:0] chk_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ecnt = 0;
    int exp_ccnt = 0;

    shift_reg_monitor #(.ERR_CNT_W(8), .CHK_CNT_W(16)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .ENB         (enb),
        .DIR         (dir),
        .S_IN        (s_in),
        .MODO        (modo),
        .D           (d),
        .Q           (q),
        .S_OUT       (s_out),
        .EXP_Q       (exp_q),
        .MODEL_VALID (model_valid),
        .ERR         (err),
        .ERR_STICKY  (err_sticky),
        .ERR_CNT     (err_cnt),
        .CHK_CNT     (chk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    endtask

    // Apply one edge's worth of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic e, input logic dr, input logic si, input logic [1:0] m,
                         input logic [3:0] dd, input logic [3:0] qq, input logic so);
        enb = e; dir = dr; s_in = si; modo = m; d = dd; q = qq; s_out = so;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] shr_q   [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
    logic       shr_so  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] shr_exp [5] = '{4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
    logic [3:0] rot_q   [4] = '{4'b1100, 4'b0000, 4'b0011, 4'b0110};
    logic [3:0] rot_exp [4] = '{4'b1001, 4'b0011, 4'b0110, 4'b1100};
    logic       rot_err [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0;
        enb = 1'b0; dir = DIR_RIGHT; s_in = 1'b0; modo = MODE_HOLD;
        d = '0; q = '0; s_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_exp_q", 32'(exp_q), 32'h0);
        check("reset_valid", 32'(model_valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_sticky", 32'(err_sticky), 32'h0);
        check("reset_ecnt", 32'(err_cnt), 32'h0);
        check("reset_ccnt", 32'(chk_cnt), 32'h0);
        rst_n = 1'b1;

        // Unseeded model: random Q must never be checked.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DIR_RIGHT, 1'b0, MODE_SHIFT, 4'($urandom), 4'($urandom), 1'($urandom));
            check("noload_err", 32'(err), 32'h0);
        end
        check("noload_ccnt", 32'(chk_cnt), 32'h0);
        check("noload_valid", 32'(model_valid), 32'h0);
        check("noload_exp_q", 32'(exp_q), 32'h0);

        // Seed with 1000 then shift right with S_IN = 0.
        drive(1'b1, DIR_RIGHT, 1'b0, MODE_PARA_LOAD, 4'b1000, 4'b0000, 1'b0);
        check("load1_exp_q", 32'(exp_q), 32'h8);
        check("load1_valid", 32'(model_valid), 32'h1);
        check("load1_ccnt", 32'(chk_cnt), 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DIR_RIGHT, 1'b0, MODE_SHIFT, 4'b0000, shr_q[i], shr_so[i]);
            exp_ccnt++;
            check("shr_exp_q", 32'(exp_q), 32'(shr_exp[i]));
            check("shr_err", 32'(err), 32'h0);
        end
        check("shr_ccnt", 32'(chk_cnt), 32'(exp_ccnt));
        check("shr_sticky", 32'(err_sticky), 32'h0);

        // Load 1100 then rotate left, with Q forced to 0000 on the second cycle.
        drive(1'b1, DIR_LEFT, 1'b0, MODE_PARA_LOAD, 4'b1100, 4'b0000, 1'b0);
        exp_ccnt++;
        check("load2_exp_q", 32'(exp_q), 32'hC);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DIR_LEFT, 1'b0, MODE_ROTATE, 4'b0000, rot_q[i], 1'b0);
            exp_ccnt++;
            if (rot_err[i]) exp_ecnt++;
            check("rotl_exp_q", 32'(exp_q), 32'(rot_exp[i]));
            check("rotl_err", 32'(err), 32'(rot_err[i]));
        end
        check("rotl_sticky", 32'(err_sticky), 32'h1);
        check("rotl_ecnt", 32'(err_cnt), 32'(exp_ecnt));
        check("rotl_ccnt", 32'(chk_cnt), 32'(exp_ccnt));

        // Load 1010, then ENB low with SHIFT selected: model must hold.
        drive(1'b1, DIR_RIGHT, 1'b1, MODE_PARA_LOAD, 4'b1010, 4'b1100, 1'b0);
        exp_ccnt++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, DIR_RIGHT, 1'b1, MODE_SHIFT, 4'b0101, 4'b1010, 1'b0);
            exp_ccnt++;
            check("enb0_exp_q", 32'(exp_q), 32'hA);
            check("enb0_err", 32'(err), 32'h0);
        end
        check("enb0_ccnt", 32'(chk_cnt), 32'(exp_ccnt));

        // Serial output check: load 0001, shift right, S_OUT stuck at 0.
        drive(1'b1, DIR_RIGHT, 1'b0, MODE_PARA_LOAD, 4'b0001, 4'b1010, 1'b0);
        exp_ccnt++;
        drive(1'b1, DIR_RIGHT, 1'b0, MODE_SHIFT, 4'b0000, 4'b0001, 1'b0);
        exp_ccnt++;
        check("sout_shift_exp_q", 32'(exp_q), 32'h0);
        check("sout_shift_err", 32'(err), 32'h0);
        drive(1'b1, DIR_RIGHT, 1'b0, MODE_HOLD, 4'b0000, 4'b0000, 1'b0);
        exp_ccnt++;
        exp_ecnt += SOUT_EN;
        check("sout_err", 32'(err), 32'(SOUT_EN));
        check("sout_ecnt", 32'(err_cnt), 32'(exp_ecnt));

        // Permanent Q mismatch: error counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, DIR_RIGHT, 1'b0, MODE_HOLD, 4'b0000, 4'b1111, 1'b0);
            exp_ccnt++;
            exp_ecnt = (exp_ecnt < 255) ? exp_ecnt + 1 : 255;
            if (i == 0 || i == 100 || i == 299) begin
                check("sat_err", 32'(err), 32'h1);
                check("sat_ecnt", 32'(err_cnt), 32'(exp_ecnt));
            end
        end
        check("sat_ccnt", 32'(chk_cnt), 32'(exp_ccnt));

        // Reset asserted mid-cycle clears everything without waiting for an edge.
        #3 rst_n = 1'b0;
        #1;
        check("midrst_exp_q", 32'(exp_q), 32'h0);
        check("midrst_valid", 32'(model_valid), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        check("midrst_sticky", 32'(err_sticky), 32'h0);
        check("midrst_ecnt", 32'(err_cnt), 32'h0);
        check("midrst_ccnt", 32'(chk_cnt), 32'h0);
        #1 rst_n = 1'b1;

        // Model must be re-seeded before any further checking.
        drive(1'b1, DIR_RIGHT, 1'b0, MODE_SHIFT, 4'b0000, 4'b1111, 1'b1);
        check("reseed_err", 32'(err), 32'h0);
        check("reseed_ccnt", 32'(chk_cnt), 32'h0);
        drive(1'b1, DIR_RIGHT, 1'b0, MODE_PARA_LOAD, 4'b0110, 4'b1111, 1'b0);
        check("reseed_valid", 32'(model_valid), 32'h1);
        check("reseed_exp_q", 32'(exp_q), 32'h6);
        check("reseed_ccnt0", 32'(chk_cnt), 32'h0);

        // Remaining directions: rotate right and shift left.
        drive(1'b1, DIR_RIGHT, 1'b0, MODE_ROTATE, 4'b0000, 4'b0110, 1'b0);
        check("rotr_exp_q", 32'(exp_q), 32'h3);
        drive(1'b1, DIR_LEFT, 1'b1, MODE_SHIFT, 4'b0000, 4'b0011, 1'b0);
        check("shl_exp_q", 32'(exp_q), 32'h7);
        drive(1'b1, DIR_RIGHT, 1'b0, MODE_ROTATE, 4'b0000, 4'b0111, 1'b0);
        check("rotr2_exp_q", 32'(exp_q), 32'hB);
        check("tail_err", 32'(err), 32'h0);
        check("tail_ecnt", 32'(err_cnt), 32'h0);
        check("tail_ccnt", 32'(chk_cnt), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_monitor.md
# shift_reg_monitor

Synthesizable checker on the output side of the 4-bit universal shift register. It samples the same control/data lines that drive the register (ENB, DIR, S_IN, MODO, D), runs a cycle-accurate reference model, and compares the register's Q and S_OUT against it every clock. It reports per-cycle errors, a sticky error flag and saturating check/error counters. It sits beside the register in every test harness and in the FPGA demo build.

## Interface
Parameters:
- ERR_CNT_W, 8, width of saturating error counter
- CHK_CNT_W, 16, width of saturating check counter

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- ENB  in  1  register enable, mirrored from the register input (1 = enabled)
- DIR  in  1  shift direction: 1 = right, 0 = left
- S_IN  in  1  serial input bit
- MODO  in  2  mode select
- D  in  4  parallel load data
- Q  in  4  register parallel output under check
- S_OUT  in  1  register serial output under check
- EXP_Q  out  4  model's expected Q
- MODEL_VALID  out  1  model has been seeded by a parallel load
- ERR  out  1  mismatch detected at the last edge (one-cycle pulse)
- ERR_STICKY  out  1  set on first ERR, cleared only by reset
- ERR_CNT  out  ERR_CNT_W  saturating count of ERR pulses
- CHK_CNT  out  CHK_CNT_W  saturating count of comparisons performed

## Operation
- Modes: 2'b00 SHIFT, 2'b01 ROTATE, 2'b10 PARA_LOAD, 2'b11 HOLD.
- Model update at each rising edge when ENB = 1:
  - PARA_LOAD: EXP_Q <= D; MODEL_VALID <= 1; expected S_OUT holds.
  - SHIFT right: EXP_Q <= {S_IN, EXP_Q[3:1]}, exp S_OUT <= EXP_Q[0]. Left: EXP_Q <= {EXP_Q[2:0], S_IN}, exp S_OUT <= EXP_Q[3].
  - ROTATE right: EXP_Q <= {EXP_Q[0], EXP_Q[3:1]}; left: {EXP_Q[2:0], EXP_Q[3]}; exp S_OUT holds.
  - HOLD: no change.
- ENB = 0: model holds regardless of MODO.
- Comparison at each rising edge when MODEL_VALID = 1, using pre-edge values: mismatch = (Q != EXP_Q) or (S_OUT != exp S_OUT, see Configuration). CHK_CNT increments; on mismatch ERR <= 1, ERR_STICKY <= 1, ERR_CNT increments.
- Before first parallel load: no comparison, CHK_CNT/ERR_CNT unchanged, ERR = 0.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset values: EXP_Q = 0, exp S_OUT = 0, MODEL_VALID = 0, ERR = 0, ERR_STICKY = 0, ERR_CNT = 0, CHK_CNT = 0.
- Model and register update on the same edge; EXP_Q equals correct Q throughout the following cycle.
- ERR latency: a wrong Q present during cycle k is flagged at edge k+1; ERR high for cycle k+1 only, unless the next check also fails.
- The edge that seeds the model (first PARA_LOAD) performs no check; the first check occurs on the following edge.
- Reset mid-operation: all state cleared immediately; MODEL_VALID must be re-seeded by a new PARA_LOAD.
- MODO/D changes between edges have no effect; only edge samples matter.

## Configuration
- MONITOR_SOUT_CHECK_EN defined: S_OUT is compared against exp S_OUT.
- Not defined: only Q is compared. The exp S_OUT register and S_OUT compare are removed, and S_OUT is unused.

## Structure
- shift_reg_pkg: mode constants (MODE_SHIFT, MODE_ROTATE, MODE_PARA_LOAD, MODE_HOLD) and DIR_RIGHT/DIR_LEFT; the register RTL also uses this package.
- Sub-module shift_reg_model: EXP_Q, exp S_OUT and MODEL_VALID update logic. The top level adds the compare logic and counters.

## Test plan
- Reset release, no load, 10 SHIFT cycles with random Q -> ERR = 0, CHK_CNT = 0, MODEL_VALID = 0.
- D = 4'b1000, PARA_LOAD, then right SHIFT with S_IN = 0, correct register -> EXP_Q 1000, 0100, 0010, 0001, 0000; ERR never set; CHK_CNT = 5 after 5 shift edges.
- D = 4'b1100, PARA_LOAD, left ROTATE for 4 cycles -> EXP_Q 1001, 0011, 0110, 1100; Q forced to 0000 on cycle 2 -> one ERR pulse, ERR_STICKY = 1, ERR_CNT = 1.
- ENB = 0 with MODO = SHIFT for 3 cycles after loading 4'b1010 -> EXP_Q stays 1010; matching Q gives no ERR.
- With MONITOR_SOUT_CHECK_EN, load 4'b0001, right SHIFT, S_OUT held 0 -> ERR at the next edge (exp S_OUT = 1). Without the macro -> no ERR.
- Force a permanent Q mismatch for 300 cycles -> ERR_CNT saturates at 255; then assert RST_N low mid-cycle -> all outputs 0 immediately.
